sm_axil_config_loader: RTL and testbench
========================================

// Module: sm_axil_config_loader
// PURPOSE
//  AXI4-Lite slave that loads the Sherman-Morrison detector's configuration: the inverse correlation matrix, and up to
//  NUM_SIGNATURES target signatures through auto-incrementing data ports. Also holds the core enable.
//  Sits between the axi_vip / PS master and the matrix/signature RAMs of the detector datapath.
//  Successor of the fixed 16-band loader: band count, data width and signature count are parametrised.
//  Adds fill tracking, overflow/locked error responses, pointer clear and readback.
// PARAMETERS
//  NUM_BANDS              16  bands per pixel; matrix is NUM_BANDS x NUM_BANDS, signature is NUM_BANDS words (2..255)
//  CORRELATION_DATA_WIDTH 32  matrix/signature word width (<=32, taken from WDATA LSBs)
//  NUM_SIGNATURES         1   number of signature banks (1..16)
//  ADDR_WIDTH             5   AXI-Lite address width (byte address, 32-bit registers)
// PORTS
//  clk            in   1                  system clock
//  resetn         in   1                  async active-low reset
//  s_axi_awaddr   in   ADDR_WIDTH         write address
//  s_axi_awvalid / s_axi_awready  in/out 1 write-address handshake
//  s_axi_wdata    in   32                 write data (WSTRB ignored, full-word writes only)
//  s_axi_wvalid / s_axi_wready    in/out 1 write-data handshake
//  s_axi_bresp    out  2                  00 OKAY, 10 SLVERR
//  s_axi_bvalid / s_axi_bready    out/in 1 write response
//  s_axi_araddr   in   ADDR_WIDTH         read address
//  s_axi_arvalid / s_axi_arready  in/out 1 read-address handshake
//  s_axi_rdata    out  32                 read data
//  s_axi_rresp    out  2                  always 00
//  s_axi_rvalid / s_axi_rready    out/in 1 read data handshake
//  mat_wr_en      out  1                  one-cycle matrix RAM write strobe
//  mat_wr_addr    out  clog2(NB*NB)       linear row-major matrix index
//  sig_wr_en      out  1                  one-cycle signature RAM write strobe
//  sig_wr_sel     out  max(1,clog2(NS))   target signature bank
//  sig_wr_addr    out  clog2(NB)          band index
//  cfg_wr_data    out  CORRELATION_DATA_WIDTH  data for either strobe
//  core_enable    out  1                  detector run enable
//  cfg_ready      out  1                  matrix full AND every signature bank full
// BEHAVIOUR
//  Map: 0x00 CTRL RW; 0x04 MATRIX WO; 0x08 SIGNATURE WO; 0x0C STATUS RO; 0x10 SIG_SEL RW.
//  Unmapped write: ignored, OKAY. Unmapped read: 0.
//  CTRL: bit0 enable; bit1 clear (self-clearing).
//    Clear zeroes all counters, enable and the sticky error bit; it wins over bit0 in the same write.
//  Reset: every registered output 0, counters 0, SIG_SEL 0.
//  Write FSM: W_IDLE / W_RESP.
//    AW and W are accepted independently in W_IDLE; awready=1 while no AW is held, wready=1 while no W is held.
//    On the cycle both are held: commit the write. The next cycle drives mem strobe/addr/data (exactly 1 cycle),
//    raises bvalid and enters W_RESP.
//    bvalid holds until bready, then W_IDLE. Total latency: 1 cycle from the last of AW/W to bvalid.
//  MATRIX write: when count < NB*NB and enable=0, write at addr=count, then count++.
//    Otherwise no strobe, count unchanged, SLVERR, error bit set.
//  SIGNATURE write: same rules, using the SIG_SEL bank's own counter (limit NB).
//  SIG_SEL write: value >= NS -> SLVERR, keep old value.
//  CTRL bit0=1 while cfg_ready=0: enable stays 0, SLVERR.
//    bit0=0 always clears enable, OKAY.
//  Data/sig writes while enable=1 -> SLVERR (tables locked during run). Clearing via CTRL bit1 is always allowed.
//  Read FSM: arready=1 when rvalid=0. rvalid and rdata are valid the cycle after the AR handshake; held until rready.
//    Reads and writes are independent.
//  STATUS: [0] mat full; [1] all sig full; [2] enable; [3] sticky error; [15:8] count of selected sig bank;
//    [31:16] matrix count.
//  Counters saturate at their limit and never wrap. Refill requires clear.
//  Async reset mid-transaction: all handshakes drop, the held AW/W are discarded, and no strobe is issued.
// TESTING
//  NB=16 upload: 16 SIG writes of 500000000, then 256 MAT writes.
//    -> 272 one-cycle strobes, addresses 0..15 and 0..255; cfg_ready=1; STATUS=0x0100_1003.
//  Write CTRL=1 -> core_enable=1, OKAY. Then a MAT write -> SLVERR, no strobe, STATUS[3]=1.
//  After a full matrix, 257th MAT write -> SLVERR, count stays 256.
//    CTRL=2 -> counts 0, enable 0, error 0.
//  CTRL=1 with an empty matrix -> SLVERR, core_enable stays 0.
//  NS=4: SIG_SEL=2 then 16 SIG writes -> sig_wr_sel=2 on all strobes. SIG_SEL=5 -> SLVERR.
//  Ordering/backpressure: W before AW by 3 cycles and bready low for 5 cycles -> exactly one strobe, bvalid held.
//    Then assert resetn=0 mid-AW -> all outputs 0.

Source files
------------

// File: rtl/sm_axil_config_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : sm_axil_config_loader_if
// Purpose  : AXI4-Lite channel bundle between a PS/VIP master and the loader.
// Revision : 1.0  initial release
// ============================================================================
interface sm_axil_config_loader_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] s_axi_awaddr;
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;
    logic [31:0]           s_axi_wdata;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;
    logic [ADDR_WIDTH-1:0] s_axi_araddr;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [31:0]           s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
               s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
               s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface
`default_nettype wire

// File: rtl/sm_axil_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : sm_axil_config_loader
// Purpose  : AXI4-Lite loader for the Sherman-Morrison inverse-correlation
//            matrix and signature banks, with fill tracking and core enable.
// Revision : 1.0  initial release
// ============================================================================
module sm_axil_config_loader #(
    parameter int NUM_BANDS              = 16,
    parameter int CORRELATION_DATA_WIDTH = 32,
    parameter int NUM_SIGNATURES         = 1,
    parameter int ADDR_WIDTH             = 5,
    localparam int MAT_AW = $clog2(NUM_BANDS * NUM_BANDS),
    localparam int SIG_AW = $clog2(NUM_BANDS),
    localparam int SEL_W  = (NUM_SIGNATURES > 1) ? $clog2(NUM_SIGNATURES) : 1
) (
    input  wire logic                              clk,
    input  wire logic                              resetn,
    sm_axil_config_loader_if.slave                 s_axi,
    output logic                                   mat_wr_en,
    output logic [MAT_AW-1:0]                      mat_wr_addr,
    output logic                                   sig_wr_en,
    output logic [SEL_W-1:0]                       sig_wr_sel,
    output logic [SIG_AW-1:0]                      sig_wr_addr,
    output logic [CORRELATION_DATA_WIDTH-1:0]      cfg_wr_data,
    output logic                                   core_enable,
    output logic                                   cfg_ready
);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;

    localparam int NSEL = 2 ** SEL_W;

    localparam logic [15:0] C_MAT_LIMIT = 16'(NUM_BANDS * NUM_BANDS);
    localparam logic [7:0]  C_SIG_LIMIT = 8'(NUM_BANDS);

    localparam logic [ADDR_WIDTH-1:0] C_ADDR_CTRL   = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_MATRIX = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_SIG    = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_STATUS = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_SEL    = ADDR_WIDTH'(8'h10);

    logic                              r_live;
    logic [0:0]                        r_wstate;
    logic                              r_aw_held;
    logic                              r_w_held;
    logic [ADDR_WIDTH-1:0]             r_awaddr;
    logic [31:0]                       r_wdata;
    logic                              r_bvalid;
    logic [1:0]                        r_bresp;
    logic                              r_rvalid;
    logic [31:0]                       r_rdata;
    logic                              r_mat_wr_en;
    logic [MAT_AW-1:0]                 r_mat_wr_addr;
    logic                              r_sig_wr_en;
    logic [SEL_W-1:0]                  r_sig_wr_sel;
    logic [SIG_AW-1:0]                 r_sig_wr_addr;
    logic [CORRELATION_DATA_WIDTH-1:0] r_cfg_wr_data;
    logic                              r_enable;
    logic                              r_error;
    logic [SEL_W-1:0]                  r_sig_sel;
    logic [15:0]                       r_mat_cnt;
    logic [7:0]                        r_sig_cnt [NSEL];

    logic                  w_awready, w_wready, w_arready;
    logic                  w_aw_fire, w_w_fire, w_ar_fire;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [31:0]           w_wdata;
    logic                  w_mat_full;
    logic [NSEL-1:0]       w_sig_full;
    logic                  w_all_sig_full;
    logic                  w_cfg_ready;
    logic [7:0]            w_sel_cnt;
    logic                  w_slverr, w_set_err, w_do_mat, w_do_sig, w_clear, w_en_next;
    logic [SEL_W-1:0]      w_sel_next;
    logic [31:0]           w_rd;

    // r_live keeps every ready low until the first edge after reset release
    assign w_awready = r_live && (r_wstate == W_IDLE) && !r_aw_held;
    assign w_wready  = r_live && (r_wstate == W_IDLE) && !r_w_held;
    assign w_arready = r_live && !r_rvalid;
    assign w_aw_fire = s_axi.s_axi_awvalid && w_awready;
    assign w_w_fire  = s_axi.s_axi_wvalid && w_wready;
    assign w_ar_fire = s_axi.s_axi_arvalid && w_arready;

    // Commit in the same cycle the last of AW/W lands, so bvalid follows one cycle later
    assign w_commit = (r_wstate == W_IDLE) && (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);
    assign w_waddr  = r_aw_held ? r_awaddr : s_axi.s_axi_awaddr;
    assign w_wdata  = r_w_held ? r_wdata : s_axi.s_axi_wdata;

    assign w_mat_full = (r_mat_cnt >= C_MAT_LIMIT);
    assign w_sel_cnt  = r_sig_cnt[r_sig_sel];

    always_comb begin
        w_sig_full = '0;
        for (int i = 0; i < NSEL; i++) begin
            w_sig_full[i] = (i >= NUM_SIGNATURES) || (r_sig_cnt[i] >= C_SIG_LIMIT);
        end
    end

    assign w_all_sig_full = &w_sig_full;
    assign w_cfg_ready    = w_mat_full && w_all_sig_full;

    always_comb begin
        w_slverr   = 1'b0;
        w_set_err  = 1'b0;
        w_do_mat   = 1'b0;
        w_do_sig   = 1'b0;
        w_clear    = 1'b0;
        w_en_next  = r_enable;
        w_sel_next = r_sig_sel;
        case (w_waddr)
            C_ADDR_CTRL: begin
                if (w_wdata[1]) begin
                    w_clear = 1'b1;
                end else if (w_wdata[0]) begin
                    if (w_cfg_ready) w_en_next = 1'b1;
                    else             w_slverr  = 1'b1;
                end else begin
                    w_en_next = 1'b0;
                end
            end
            C_ADDR_MATRIX: begin
                if (!r_enable && !w_mat_full) begin
                    w_do_mat = 1'b1;
                end else begin
                    w_slverr  = 1'b1;
                    w_set_err = 1'b1;
                end
            end
            C_ADDR_SIG: begin
                if (!r_enable && (w_sel_cnt < C_SIG_LIMIT)) begin
                    w_do_sig = 1'b1;
                end else begin
                    w_slverr  = 1'b1;
                    w_set_err = 1'b1;
                end
            end
            C_ADDR_SEL: begin
                if (w_wdata < 32'(NUM_SIGNATURES)) w_sel_next = w_wdata[SEL_W-1:0];
                else                               w_slverr   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_live        <= 1'b0;
            r_wstate      <= W_IDLE;
            r_aw_held     <= 1'b0;
            r_w_held      <= 1'b0;
            r_awaddr      <= '0;
            r_wdata       <= '0;
            r_bvalid      <= 1'b0;
            r_bresp       <= 2'b00;
            r_mat_wr_en   <= 1'b0;
            r_mat_wr_addr <= '0;
            r_sig_wr_en   <= 1'b0;
            r_sig_wr_sel  <= '0;
            r_sig_wr_addr <= '0;
            r_cfg_wr_data <= '0;
            r_enable      <= 1'b0;
            r_error       <= 1'b0;
            r_sig_sel     <= '0;
            r_mat_cnt     <= '0;
            for (int i = 0; i < NSEL; i++) r_sig_cnt[i] <= '0;
        end else begin
            r_live      <= 1'b1;
            r_mat_wr_en <= 1'b0;
            r_sig_wr_en <= 1'b0;
            if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_axi.s_axi_awaddr;
            end
            if (w_w_fire) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi.s_axi_wdata;
            end
            case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_slverr ? 2'b10 : 2'b00;
                        r_wstate  <= W_RESP;
                        r_enable  <= w_en_next;
                        r_sig_sel <= w_sel_next;
                        if (w_set_err) r_error <= 1'b1;
                        if (w_do_mat) begin
                            r_mat_wr_en   <= 1'b1;
                            r_mat_wr_addr <= r_mat_cnt[MAT_AW-1:0];
                            r_cfg_wr_data <= w_wdata[CORRELATION_DATA_WIDTH-1:0];
                            r_mat_cnt     <= r_mat_cnt + 16'd1;
                        end
                        if (w_do_sig) begin
                            r_sig_wr_en          <= 1'b1;
                            r_sig_wr_sel         <= r_sig_sel;
                            r_sig_wr_addr        <= w_sel_cnt[SIG_AW-1:0];
                            r_cfg_wr_data        <= w_wdata[CORRELATION_DATA_WIDTH-1:0];
                            r_sig_cnt[r_sig_sel] <= w_sel_cnt + 8'd1;
                        end
                        if (w_clear) begin
                            r_enable  <= 1'b0;
                            r_error   <= 1'b0;
                            r_mat_cnt <= '0;
                            for (int i = 0; i < NSEL; i++) r_sig_cnt[i] <= '0;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.s_axi_bready) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd = '0;
        case (s_axi.s_axi_araddr)
            C_ADDR_CTRL:   w_rd[0] = r_enable;
            C_ADDR_STATUS: w_rd = {r_mat_cnt, w_sel_cnt, 4'b0000, r_error, r_enable, w_all_sig_full, w_mat_full};
            C_ADDR_SEL:    w_rd[SEL_W-1:0] = r_sig_sel;
            default:       w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd;
        end else if (r_rvalid && s_axi.s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_axi.s_axi_awready = w_awready;
    assign s_axi.s_axi_wready  = w_wready;
    assign s_axi.s_axi_bvalid  = r_bvalid;
    assign s_axi.s_axi_bresp   = r_bresp;
    assign s_axi.s_axi_arready = w_arready;
    assign s_axi.s_axi_rvalid  = r_rvalid;
    assign s_axi.s_axi_rdata   = r_rdata;
    assign s_axi.s_axi_rresp   = 2'b00;

    assign mat_wr_en   = r_mat_wr_en;
    assign mat_wr_addr = r_mat_wr_addr;
    assign sig_wr_en   = r_sig_wr_en;
    assign sig_wr_sel  = r_sig_wr_sel;
    assign sig_wr_addr = r_sig_wr_addr;
    assign cfg_wr_data = r_cfg_wr_data;
    assign core_enable = r_enable;
    assign cfg_ready   = w_cfg_ready;

endmodule
`default_nettype wire

// File: tb/tb_sm_axil_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_axil_config_loader
// Purpose  : Scoreboard bench for the AXI-Lite config loader (NB=16, NS=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_sm_axil_config_loader;

    localparam int NB = 16;
    localparam int NS = 4;
    localparam int AW = 5;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sm_axil_config_loader_if #(.ADDR_WIDTH(AW)) bus ();

    logic        mat_wr_en;
    logic [7:0]  mat_wr_addr;
    logic        sig_wr_en;
    logic [1:0]  sig_wr_sel;
    logic [3:0]  sig_wr_addr;
    logic [31:0] cfg_wr_data;
    logic        core_enable;
    logic        cfg_ready;

    sm_axil_config_loader #(
        .NUM_BANDS(NB), .CORRELATION_DATA_WIDTH(32), .NUM_SIGNATURES(NS), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .resetn(resetn), .s_axi(bus),
        .mat_wr_en(mat_wr_en), .mat_wr_addr(mat_wr_addr),
        .sig_wr_en(sig_wr_en), .sig_wr_sel(sig_wr_sel), .sig_wr_addr(sig_wr_addr),
        .cfg_wr_data(cfg_wr_data), .core_enable(core_enable), .cfg_ready(cfg_ready)
    );

    typedef struct packed {
        logic        is_sig;
        logic [1:0]  sel;
        logic [7:0]  addr;
        logic [31:0] data;
    } strobe_t;

    strobe_t exp_q [$];
    strobe_t mon_got, mon_exp;
    int checks    = 0;
    int failures  = 0;
    int n_strobes = 0;

    int m_mat;
    int m_sig [NS];
    int m_sel;
    bit m_en;

    always @(negedge clk) begin
        if (resetn && (mat_wr_en || sig_wr_en)) begin
            n_strobes++;
            mon_got.is_sig = sig_wr_en;
            mon_got.sel    = sig_wr_en ? sig_wr_sel : 2'd0;
            mon_got.addr   = sig_wr_en ? {4'd0, sig_wr_addr} : mat_wr_addr;
            mon_got.data   = cfg_wr_data;
            checks++;
            if (mat_wr_en && sig_wr_en) begin
                failures++;
                $display("FAIL strobe_both got mat+sig required one");
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL strobe_unexpected got=%h required=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL strobe got=%h required=%h", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, output logic [1:0] resp);
        bit aw_done, w_done, aw_f, w_f;
        aw_done = 0; w_done = 0; resp = 2'bxx;
        @(posedge clk); #1;
        bus.s_axi_awaddr = a; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata  = d; bus.s_axi_wvalid  = 1'b1;
        for (int n = 0; n < 40 && !(aw_done && w_done); n++) begin
            @(negedge clk);
            aw_f = bus.s_axi_awvalid && bus.s_axi_awready;
            w_f  = bus.s_axi_wvalid && bus.s_axi_wready;
            @(posedge clk); #1;
            if (aw_f) begin aw_done = 1; bus.s_axi_awvalid = 1'b0; end
            if (w_f)  begin w_done = 1;  bus.s_axi_wvalid  = 1'b0; end
        end
        @(negedge clk);
        checks++;
        if (!(aw_done && w_done) || bus.s_axi_bvalid !== 1'b1) begin
            failures++;
            $display("FAIL wr_bvalid_latency addr=%h got_bvalid=%b required=1", a, bus.s_axi_bvalid);
            bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        end else begin
            resp = bus.s_axi_bresp;
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        bit done, f;
        done = 0; d = 'x;
        @(posedge clk); #1;
        bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            f = bus.s_axi_arvalid && bus.s_axi_arready;
            @(posedge clk); #1;
            if (f) begin done = 1; bus.s_axi_arvalid = 1'b0; end
        end
        @(negedge clk);
        checks++;
        if (!done || bus.s_axi_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL rd_rvalid_latency addr=%h got_rvalid=%b required=1", a, bus.s_axi_rvalid);
            bus.s_axi_arvalid = 1'b0;
        end else begin
            d = bus.s_axi_rdata;
        end
        @(posedge clk); #1;
    endtask

    task automatic wr_mat(input logic [31:0] d, input string tag);
        logic [1:0] r, er;
        strobe_t s;
        if (!m_en && m_mat < NB * NB) begin
            s.is_sig = 1'b0; s.sel = 2'd0; s.addr = 8'(m_mat); s.data = d;
            exp_q.push_back(s);
            m_mat++;
            er = 2'b00;
        end else begin
            er = 2'b10;
        end
        axi_write(5'h04, d, r);
        checks++;
        if (r !== er) begin
            failures++;
            $display("FAIL %s bresp got=%b required=%b", tag, r, er);
        end
    endtask

    task automatic wr_sig(input logic [31:0] d, input string tag);
        logic [1:0] r, er;
        strobe_t s;
        if (!m_en && m_sig[m_sel] < NB) begin
            s.is_sig = 1'b1; s.sel = 2'(m_sel); s.addr = 8'(m_sig[m_sel]); s.data = d;
            exp_q.push_back(s);
            m_sig[m_sel]++;
            er = 2'b00;
        end else begin
            er = 2'b10;
        end
        axi_write(5'h08, d, r);
        checks++;
        if (r !== er) begin
            failures++;
            $display("FAIL %s bresp got=%b required=%b", tag, r, er);
        end
    endtask

    function automatic logic [89:0] out_vec();
        return {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready, bus.s_axi_bvalid,
                bus.s_axi_rvalid, bus.s_axi_bresp, bus.s_axi_rdata, mat_wr_en, mat_wr_addr,
                sig_wr_en, sig_wr_sel, sig_wr_addr, cfg_wr_data, core_enable, cfg_ready};
    endfunction

    task automatic model_reset();
        m_mat = 0; m_sel = 0; m_en = 0;
        for (int i = 0; i < NS; i++) m_sig[i] = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        checks++;
        if (out_vec() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", out_vec());
        end
        @(posedge clk); #1 resetn = 1'b1;
        axi_read(5'h0C, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_status got=%h required=0", d); end
        axi_read(5'h10, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_sigsel got=%h required=0", d); end
    endtask

    task automatic test_enable_empty();
        logic [1:0] r;
        axi_write(5'h00, 32'h1, r);
        checks++;
        if (r !== 2'b10) begin failures++; $display("FAIL enable_empty bresp got=%b required=10", r); end
        checks++;
        if (core_enable !== 1'b0) begin failures++; $display("FAIL enable_empty core_enable got=%b required=0", core_enable); end
    endtask

    task automatic test_sig_sel();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(5'h10, 32'd5, r);
        checks++;
        if (r !== 2'b10) begin failures++; $display("FAIL sigsel_range bresp got=%b required=10", r); end
        axi_read(5'h10, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL sigsel_keep got=%h required=0", d); end
        axi_write(5'h10, 32'd2, r);
        m_sel = 2;
        checks++;
        if (r !== 2'b00) begin failures++; $display("FAIL sigsel_set bresp got=%b required=00", r); end
        for (int i = 0; i < NB; i++) wr_sig(32'd500000000, "sig_bank2");
        axi_read(5'h0C, d);
        checks++;
        if (d !== 32'h0000_1000) begin failures++; $display("FAIL sig_bank2_status got=%h required=00001000", d); end
    endtask

    task automatic test_upload();
        logic [1:0]  r;
        logic [31:0] d;
        int          s0;
        s0 = n_strobes;
        for (int b = 0; b < NS; b++) begin
            if (b != 2) begin
                axi_write(5'h10, 32'(b), r);
                m_sel = b;
                checks++;
                if (r !== 2'b00) begin failures++; $display("FAIL upload_sel%0d bresp got=%b required=00", b, r); end
                for (int i = 0; i < NB; i++) wr_sig(32'(b * 1000 + i + 7), "sig_upload");
            end
        end
        for (int i = 0; i < NB * NB; i++) begin
            if (i == NB * NB - 1) begin
                checks++;
                if (cfg_ready !== 1'b0) begin failures++; $display("FAIL cfg_ready_early got=%b required=0", cfg_ready); end
            end
            wr_mat(32'(i) * 32'h0001_0003 ^ 32'hA5A5_0000, "mat_upload");
        end
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1) begin failures++; $display("FAIL cfg_ready_full got=%b required=1", cfg_ready); end
        checks++;
        if (n_strobes - s0 != 3 * NB + NB * NB) begin
            failures++;
            $display("FAIL upload_strobe_count got=%0d required=%0d", n_strobes - s0, 3 * NB + NB * NB);
        end
        axi_read(5'h0C, d);
        checks++;
        if (d !== 32'h0100_1003) begin failures++; $display("FAIL upload_status got=%h required=01001003", d); end
    endtask

    task automatic test_lock();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(5'h00, 32'h1, r);
        m_en = 1;
        checks++;
        if (r !== 2'b00 || core_enable !== 1'b1) begin
            failures++;
            $display("FAIL lock_enable got resp=%b en=%b required resp=00 en=1", r, core_enable);
        end
        wr_mat(32'hDEAD_BEEF, "mat_locked");
        wr_sig(32'hBEEF_DEAD, "sig_locked");
        axi_read(5'h0C, d);
        checks++;
        if (d !== 32'h0100_100F) begin failures++; $display("FAIL lock_status got=%h required=0100100F", d); end
        axi_read(5'h00, d);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL lock_ctrl_read got=%h required=1", d); end
    endtask

    task automatic test_overflow_clear();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(5'h00, 32'h0, r);
        m_en = 0;
        checks++;
        if (r !== 2'b00 || core_enable !== 1'b0) begin
            failures++;
            $display("FAIL disable got resp=%b en=%b required resp=00 en=0", r, core_enable);
        end
        wr_mat(32'h1234_5678, "mat_overflow");
        axi_read(5'h0C, d);
        checks++;
        if (d !== 32'h0100_100B) begin failures++; $display("FAIL overflow_status got=%h required=0100100B", d); end
        axi_write(5'h00, 32'h3, r);
        m_mat = 0;
        for (int i = 0; i < NS; i++) m_sig[i] = 0;
        checks++;
        if (r !== 2'b00 || core_enable !== 1'b0 || cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL clear got resp=%b en=%b rdy=%b required resp=00 en=0 rdy=0", r, core_enable, cfg_ready);
        end
        axi_read(5'h0C, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL clear_status got=%h required=0", d); end
        wr_mat(32'h0BAD_F00D, "mat_after_clear");
    endtask

    task automatic test_ordering();
        int   s0;
        logic [31:0] d;
        strobe_t s;
        s0 = n_strobes;
        d  = 32'h5555_AAAA;
        s.is_sig = 1'b0; s.sel = 2'd0; s.addr = 8'(m_mat); s.data = d;
        exp_q.push_back(s);
        m_mat++;
        @(posedge clk); #1;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_wdata  = d; bus.s_axi_wvalid = 1'b1; bus.s_axi_awaddr = 5'h04;
        @(negedge clk);
        checks++;
        if (bus.s_axi_wready !== 1'b1) begin failures++; $display("FAIL order_wready got=%b required=1", bus.s_axi_wready); end
        @(posedge clk); #1 bus.s_axi_wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.s_axi_wready !== 1'b0 || bus.s_axi_bvalid !== 1'b0) begin
            failures++;
            $display("FAIL order_w_held got wready=%b bvalid=%b required 0/0", bus.s_axi_wready, bus.s_axi_bvalid);
        end
        repeat (2) @(posedge clk);
        #1 bus.s_axi_awvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_axi_awready !== 1'b1) begin failures++; $display("FAIL order_awready got=%b required=1", bus.s_axi_awready); end
        @(posedge clk); #1 bus.s_axi_awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.s_axi_bvalid !== 1'b1 || bus.s_axi_bresp !== 2'b00) begin
                failures++;
                $display("FAIL order_bvalid_hold cyc=%0d got bvalid=%b bresp=%b required 1/00", i, bus.s_axi_bvalid, bus.s_axi_bresp);
            end
        end
        @(posedge clk); #1 bus.s_axi_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.s_axi_bvalid !== 1'b0) begin failures++; $display("FAIL order_bvalid_drop got=%b required=0", bus.s_axi_bvalid); end
        checks++;
        if (n_strobes - s0 != 1) begin failures++; $display("FAIL order_strobes got=%0d required=1", n_strobes - s0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        @(posedge clk); #1;
        bus.s_axi_awaddr = 5'h04; bus.s_axi_awvalid = 1'b1;
        @(posedge clk); #1 bus.s_axi_awvalid = 1'b0;
        #2 resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_vec() !== '0) begin failures++; $display("FAIL midreset_outputs got=%h required=0", out_vec()); end
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        bus.s_axi_wdata = 32'h7777_0000; bus.s_axi_wvalid = 1'b1;
        @(posedge clk); @(posedge clk); #1 bus.s_axi_wvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.s_axi_bvalid !== 1'b0) begin failures++; $display("FAIL midreset_aw_discard bvalid got=%b required=0", bus.s_axi_bvalid); end
        end
        @(posedge clk); #1;
        bus.s_axi_awaddr = 5'h14; bus.s_axi_awvalid = 1'b1;
        @(posedge clk); #1 bus.s_axi_awvalid = 1'b0;
        @(posedge clk); #1;
        axi_read(5'h0C, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL midreset_status got=%h required=0", d); end
    endtask

    initial begin
        bus.s_axi_awaddr  = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata   = '0; bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_bready  = 1'b1;
        bus.s_axi_araddr  = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready  = 1'b1;
        model_reset();

        test_reset();
        test_enable_empty();
        test_sig_sel();
        test_upload();
        test_lock();
        test_overflow_clear();
        test_ordering();
        test_reset_mid();

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size()); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
